// File: rtl/dispatch_queue_pkg.sv
// Shared constants, class encodings and decode helpers for the dispatch queue.
package dispatch_queue_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned REG_ID_BIT   = 5;
  localparam int unsigned ROB_TYPE_BIT = 2;
  localparam int unsigned RS_TYPE_BIT  = 6;
  localparam int unsigned LS_TYPE_BIT  = 4;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // ROB entry classes
  localparam logic [ROB_TYPE_BIT-1:0] ROB_TYPE_REG    = 2'd0;
  localparam logic [ROB_TYPE_BIT-1:0] ROB_TYPE_STORE  = 2'd1;
  localparam logic [ROB_TYPE_BIT-1:0] ROB_TYPE_BRANCH = 2'd2;
  localparam logic [ROB_TYPE_BIT-1:0] ROB_TYPE_JALR   = 2'd3;

  // RS type = {group[1:0], funct7[5], funct3}
  localparam logic [1:0] RS_GRP_ALU     = 2'd0;
  localparam logic [1:0] RS_GRP_ALU_IMM = 2'd1;
  localparam logic [1:0] RS_GRP_BRANCH  = 2'd2;
  localparam logic [1:0] RS_GRP_JALR    = 2'd3;

  // LS type = {is_store, funct3}
  localparam logic LS_LOAD  = 1'b0;
  localparam logic LS_STORE = 1'b1;

  typedef enum logic [3:0] {
    CLS_INVALID,
    CLS_LOAD,
    CLS_STORE,
    CLS_OP,
    CLS_OP_IMM,
    CLS_BRANCH,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL
  } inst_class_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] addr;
  } fetch_entry_t;

  // Map a major opcode to its dispatch class.
  function automatic inst_class_e classify(input logic [6:0] opcode);
    case (opcode)
      OPC_LOAD:   return CLS_LOAD;
      OPC_STORE:  return CLS_STORE;
      OPC_OP:     return CLS_OP;
      OPC_OP_IMM: return CLS_OP_IMM;
      OPC_BRANCH: return CLS_BRANCH;
      OPC_JALR:   return CLS_JALR;
      OPC_LUI:    return CLS_LUI;
      OPC_AUIPC:  return CLS_AUIPC;
      OPC_JAL:    return CLS_JAL;
      default:    return CLS_INVALID;
    endcase
  endfunction

  // Sign-extended immediate in the format the class uses.
  function automatic logic [XLEN-1:0] gen_imm(input inst_class_e cls, input logic [XLEN-1:0] inst);
    case (cls)
      CLS_LOAD, CLS_OP_IMM, CLS_JALR:
        return {{20{inst[31]}}, inst[31:20]};
      CLS_STORE:
        return {{20{inst[31]}}, inst[31:25], inst[11:7]};
      CLS_BRANCH:
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      CLS_LUI, CLS_AUIPC:
        return {inst[31:12], 12'b0};
      CLS_JAL:
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        return '0;
    endcase
  endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// Fetch, register-file, CDB, ROB, RS and LSB signals around the dispatch queue.
interface dispatch_queue_if #(
  parameter int unsigned ROB_WIDTH_BIT = 3
);
  import dispatch_queue_pkg::*;

  // fetcher
  logic                     if_valid;
  logic [XLEN-1:0]          if_inst;
  logic [XLEN-1:0]          if_inst_addr;
  logic                     if_ready;
  // register file
  logic [REG_ID_BIT-1:0]    get_reg_id1;
  logic [REG_ID_BIT-1:0]    get_reg_id2;
  logic [XLEN-1:0]          rs1_val_in;
  logic [XLEN-1:0]          rs2_val_in;
  logic                     has_dep1;
  logic                     has_dep2;
  logic [ROB_WIDTH_BIT-1:0] dep1;
  logic [ROB_WIDTH_BIT-1:0] dep2;
  logic                     rf_rename_valid;
  logic [REG_ID_BIT-1:0]    rf_rename_reg;
  logic [ROB_WIDTH_BIT-1:0] rf_rename_rob_id;
  // common data bus
  logic                     cdb_valid;
  logic [ROB_WIDTH_BIT-1:0] cdb_rob_id;
  logic [XLEN-1:0]          cdb_value;
  // ROB
  logic                     rob_full;
  logic [ROB_WIDTH_BIT-1:0] rob_free_id;
  logic                     rob_valid;
  logic [ROB_TYPE_BIT-1:0]  rob_type;
  logic [REG_ID_BIT-1:0]    rob_reg_id;
  logic [XLEN-1:0]          rob_value;
  logic                     rob_ready;
  logic [XLEN-1:0]          rob_inst_addr;
  // RS / LSB
  logic                     rs_full;
  logic                     lsb_full;
  logic                     rs_valid;
  logic                     lsb_valid;
  logic [RS_TYPE_BIT-1:0]   rs_type;
  logic [LS_TYPE_BIT-1:0]   lsb_type;
  logic [XLEN-1:0]          r1;
  logic [XLEN-1:0]          r2;
  logic                     has_dep1_out;
  logic                     has_dep2_out;
  logic [ROB_WIDTH_BIT-1:0] dep1_out;
  logic [ROB_WIDTH_BIT-1:0] dep2_out;
  logic [XLEN-1:0]          imm;
  logic [ROB_WIDTH_BIT-1:0] issue_rob_id;

  // dispatch side
  modport master (
    input  if_valid, if_inst, if_inst_addr,
    output if_ready,
    output get_reg_id1, get_reg_id2,
    input  rs1_val_in, rs2_val_in, has_dep1, has_dep2, dep1, dep2,
    output rf_rename_valid, rf_rename_reg, rf_rename_rob_id,
    input  cdb_valid, cdb_rob_id, cdb_value,
    input  rob_full, rob_free_id,
    output rob_valid, rob_type, rob_reg_id, rob_value, rob_ready, rob_inst_addr,
    input  rs_full, lsb_full,
    output rs_valid, lsb_valid, rs_type, lsb_type, r1, r2,
    output has_dep1_out, has_dep2_out, dep1_out, dep2_out, imm, issue_rob_id
  );

  // surrounding units
  modport slave (
    output if_valid, if_inst, if_inst_addr,
    input  if_ready,
    input  get_reg_id1, get_reg_id2,
    output rs1_val_in, rs2_val_in, has_dep1, has_dep2, dep1, dep2,
    input  rf_rename_valid, rf_rename_reg, rf_rename_rob_id,
    output cdb_valid, cdb_rob_id, cdb_value,
    output rob_full, rob_free_id,
    input  rob_valid, rob_type, rob_reg_id, rob_value, rob_ready, rob_inst_addr,
    output rs_full, lsb_full,
    input  rs_valid, lsb_valid, rs_type, lsb_type, r1, r2,
    input  has_dep1_out, has_dep2_out, dep1_out, dep2_out, imm, issue_rob_id
  );

endinterface

// File: rtl/dispatch_queue_inst_fifo.sv
// Circular buffer of fetched {inst, addr} entries with push, pop and flush.
module dispatch_queue_inst_fifo
  import dispatch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  fetch_entry_t                     push_data,
  input  logic                             pop,
  input  logic                             flush,
  output fetch_entry_t                     head,
  output logic [$clog2(DEPTH + 1)-1:0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;

  assign head = mem[head_ptr];

  // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= tail_ptr;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PTR_W'(1);
      if (pop)  head_ptr <= head_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful between head and tail.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail_ptr] <= push_data;
  end

endmodule

// File: rtl/dispatch_queue.sv
// Instruction queue with head decode, operand read/bypass and single-issue dispatch.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH   = 4,
  parameter int unsigned ROB_WIDTH_BIT = 3
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          flush_in,
  dispatch_queue_if.master bus
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

  fetch_entry_t             push_entry;
  fetch_entry_t             head;
  logic [CNT_W-1:0]         fifo_count;
  logic                     push;
  logic                     pop;
  logic                     fifo_flush;
  logic                     active;
  logic                     has_head;
  logic                     queue_ready;
  logic                     discard;
  logic                     issue;
  logic                     target_room;

  inst_class_e              cls;
  logic [REG_ID_BIT-1:0]    rd;
  logic [REG_ID_BIT-1:0]    rs1;
  logic [REG_ID_BIT-1:0]    rs2;
  logic [2:0]               funct3;
  logic [XLEN-1:0]          imm_val;

  logic                     to_rs;
  logic                     to_lsb;
  logic                     uses_rs1;
  logic                     uses_rs2;
  logic                     writes_rd;
  logic                     pre_ready;
  logic [XLEN-1:0]          pre_value;
  logic [ROB_TYPE_BIT-1:0]  dec_rob_type;
  logic [RS_TYPE_BIT-1:0]   dec_rs_type;
  logic [LS_TYPE_BIT-1:0]   dec_lsb_type;

  logic [XLEN-1:0]          op1;
  logic [XLEN-1:0]          op2;
  logic                     op1_dep;
  logic                     op2_dep;
  logic [ROB_WIDTH_BIT-1:0] op1_tag;
  logic [ROB_WIDTH_BIT-1:0] op2_tag;
  logic [ROB_WIDTH_BIT-1:0] free_tag;

  assign push_entry = '{inst: bus.if_inst, addr: bus.if_inst_addr};

  dispatch_queue_inst_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk       (clk_in),
    .rst_n     (rst_in),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (fifo_flush),
    .head      (head),
    .count     (fifo_count)
  );

  // Head instruction fields
  assign cls      = classify(head.inst[6:0]);
  assign rd       = head.inst[11:7];
  assign funct3   = head.inst[14:12];
  assign rs1      = head.inst[19:15];
  assign rs2      = head.inst[24:20];
  assign imm_val  = gen_imm(cls, head.inst);
  assign free_tag = bus.rob_free_id;

  // Class decode: target unit, operand usage, entry types and precomputed results.
  always_comb begin
    to_rs        = 1'b0;
    to_lsb       = 1'b0;
    uses_rs1     = 1'b0;
    uses_rs2     = 1'b0;
    writes_rd    = 1'b0;
    pre_ready    = 1'b0;
    pre_value    = '0;
    dec_rob_type = ROB_TYPE_REG;
    dec_rs_type  = '0;
    dec_lsb_type = '0;
    case (cls)
      CLS_LOAD: begin
        to_lsb       = 1'b1;
        uses_rs1     = 1'b1;
        writes_rd    = 1'b1;
        dec_lsb_type = {LS_LOAD, funct3};
      end
      CLS_STORE: begin
        to_lsb       = 1'b1;
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
        dec_rob_type = ROB_TYPE_STORE;
        dec_lsb_type = {LS_STORE, funct3};
      end
      CLS_OP: begin
        to_rs       = 1'b1;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        writes_rd   = 1'b1;
        dec_rs_type = {RS_GRP_ALU, head.inst[30], funct3};
      end
      CLS_OP_IMM: begin
        to_rs       = 1'b1;
        uses_rs1    = 1'b1;
        writes_rd   = 1'b1;
        // funct7[5] only distinguishes SRAI from SRLI; elsewhere those bits are immediate
        dec_rs_type = {RS_GRP_ALU_IMM, (funct3 == 3'b101) && head.inst[30], funct3};
      end
      CLS_BRANCH: begin
        to_rs        = 1'b1;
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
        dec_rob_type = ROB_TYPE_BRANCH;
        dec_rs_type  = {RS_GRP_BRANCH, 1'b0, funct3};
      end
      CLS_JALR: begin
        to_rs        = 1'b1;
        uses_rs1     = 1'b1;
        writes_rd    = 1'b1;
        dec_rob_type = ROB_TYPE_JALR;
        dec_rs_type  = {RS_GRP_JALR, 4'b0000};
      end
      CLS_LUI: begin
        writes_rd = 1'b1;
        pre_ready = 1'b1;
        pre_value = imm_val;
      end
      CLS_AUIPC: begin
        writes_rd = 1'b1;
        pre_ready = 1'b1;
        pre_value = head.addr + imm_val;
      end
      CLS_JAL: begin
        writes_rd = 1'b1;
        pre_ready = 1'b1;
        pre_value = head.addr + XLEN'(4);
      end
      default: ;
    endcase
  end

  // Operand resolution: unused/x0 sources are zero, a matching CDB broadcast wins over the register file.
  always_comb begin
    op1     = '0;
    op1_dep = 1'b0;
    op1_tag = '0;
    op2     = '0;
    op2_dep = 1'b0;
    op2_tag = '0;
    if (uses_rs1 && (rs1 != 5'd0)) begin
      if (bus.has_dep1 && bus.cdb_valid && (bus.cdb_rob_id == bus.dep1)) begin
        op1 = bus.cdb_value;
      end else begin
        op1     = bus.rs1_val_in;
        op1_dep = bus.has_dep1;
        op1_tag = bus.dep1;
      end
    end
    if (uses_rs2 && (rs2 != 5'd0)) begin
      if (bus.has_dep2 && bus.cdb_valid && (bus.cdb_rob_id == bus.dep2)) begin
        op2 = bus.cdb_value;
      end else begin
        op2     = bus.rs2_val_in;
        op2_dep = bus.has_dep2;
        op2_tag = bus.dep2;
      end
    end
  end

  // Issue / push / discard conditions; everything is held off during reset, freeze or flush.
  assign active      = rst_in && rdy_in && !flush_in;
  assign has_head    = (fifo_count != '0);
  assign queue_ready = rst_in && (fifo_count != CNT_W'(QUEUE_DEPTH));
  assign target_room = to_rs ? !bus.rs_full : (to_lsb ? !bus.lsb_full : 1'b1);
  assign discard     = active && has_head && (cls == CLS_INVALID);
  assign issue       = active && has_head && (cls != CLS_INVALID) && !bus.rob_full && target_room;
  assign pop         = issue || discard;
  assign push        = active && bus.if_valid && queue_ready;
  assign fifo_flush  = rdy_in && flush_in;

  // Fetch handshake and register file lookup
  assign bus.if_ready         = queue_ready;
  assign bus.get_reg_id1      = rs1;
  assign bus.get_reg_id2      = rs2;
  assign bus.rf_rename_valid  = issue && writes_rd && (rd != 5'd0);
  assign bus.rf_rename_reg    = rd;
  assign bus.rf_rename_rob_id = free_tag;

  // ROB allocation
  assign bus.rob_valid     = issue;
  assign bus.rob_type      = dec_rob_type;
  assign bus.rob_reg_id    = writes_rd ? rd : 5'd0;
  assign bus.rob_value     = pre_value;
  assign bus.rob_ready     = pre_ready;
  assign bus.rob_inst_addr = head.addr;

  // RS / LSB issue payload
  assign bus.rs_valid     = issue && to_rs;
  assign bus.lsb_valid    = issue && to_lsb;
  assign bus.rs_type      = dec_rs_type;
  assign bus.lsb_type     = dec_lsb_type;
  assign bus.r1           = op1;
  assign bus.r2           = op2;
  assign bus.has_dep1_out = op1_dep;
  assign bus.has_dep2_out = op2_dep;
  assign bus.dep1_out     = op1_tag;
  assign bus.dep2_out     = op2_tag;
  assign bus.imm          = imm_val;
  assign bus.issue_rob_id = free_tag;

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed vector bench for dispatch_queue.
module tb_dispatch_queue;

  logic clk;
  logic rst_n;
  logic rdy;
  logic flush;

  int n_checks = 0;
  int n_fail   = 0;

  dispatch_queue_if #(.ROB_WIDTH_BIT(3)) bus ();

  dispatch_queue #(
    .QUEUE_DEPTH   (4),
    .ROB_WIDTH_BIT (3)
  ) dut (
    .clk_in   (clk),
    .rst_in   (rst_n),
    .rdy_in   (rdy),
    .flush_in (flush),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1v;
    logic [31:0] rs2v;
    logic        hd1;
    logic [2:0]  d1;
    logic        hd2;
    logic [2:0]  d2;
    logic        cdbv;
    logic [2:0]  cdbid;
    logic [31:0] cdbval;
    logic        robf;
    logic        rsf;
    logic        lsbf;
    logic [2:0]  freeid;
    logic        e_rob;
    logic        e_rs;
    logic        e_lsb;
    logic        e_ren;
    logic [4:0]  e_reg;
    logic        e_ready;
    logic [31:0] e_val;
    logic [31:0] e_r1;
    logic [31:0] e_r2;
    logic        e_hd1;
    logic [2:0]  e_d1;
    logic        e_hd2;
    logic [2:0]  e_d2;
    logic [31:0] e_imm;
    logic        drain;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_inst(input logic [31:0] inst, input logic [31:0] pc);
    bus.if_valid     = 1'b1;
    bus.if_inst      = inst;
    bus.if_inst_addr = pc;
    cyc();
    bus.if_valid = 1'b0;
  endtask

  function automatic logic [31:0] addi(input int rd, input int k);
    return (32'(k) << 20) | (32'(rd) << 7) | 32'h13;
  endfunction

  task automatic quiet_inputs();
    bus.if_valid    = 1'b0;
    bus.rs1_val_in  = '0;
    bus.rs2_val_in  = '0;
    bus.has_dep1    = 1'b0;
    bus.has_dep2    = 1'b0;
    bus.dep1        = '0;
    bus.dep2        = '0;
    bus.cdb_valid   = 1'b0;
    bus.cdb_rob_id  = '0;
    bus.cdb_value   = '0;
    bus.rob_full    = 1'b0;
    bus.rs_full     = 1'b0;
    bus.lsb_full    = 1'b0;
    bus.rob_free_id = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    rdy   = 1'b1;
    flush = 1'b0;
    bus.if_inst      = '0;
    bus.if_inst_addr = '0;
    quiet_inputs();

    //              inputs ...                                                                   expected ...
    vecs[0]  = '{inst:32'h00500093, rs1v:32'h11, freeid:3'd1,
                 e_rob:1, e_rs:1, e_ren:1, e_reg:5'd1, e_imm:32'd5, default:0};
    vecs[1]  = '{inst:32'h002081B3, rs1v:32'hAAAA, rs2v:32'h22, hd1:1, d1:3'd5, cdbv:1, cdbid:3'd5, cdbval:32'h1234, freeid:3'd2,
                 e_rob:1, e_rs:1, e_ren:1, e_reg:5'd3, e_r1:32'h1234, e_r2:32'h22, default:0};
    vecs[2]  = '{inst:32'h002081B3, rs1v:32'hAAAA, rs2v:32'hBBBB, hd1:1, d1:3'd5, hd2:1, d2:3'd2, cdbv:1, cdbid:3'd6, cdbval:32'h1234, freeid:3'd3,
                 e_rob:1, e_rs:1, e_ren:1, e_reg:5'd3, e_r1:32'hAAAA, e_hd1:1, e_d1:3'd5, e_r2:32'hBBBB, e_hd2:1, e_d2:3'd2, default:0};
    vecs[3]  = '{inst:32'h00008333, rs1v:32'h10, rs2v:32'h55, hd2:1, d2:3'd3, freeid:3'd4,
                 e_rob:1, e_rs:1, e_ren:1, e_reg:5'd6, e_r1:32'h10, default:0};
    vecs[4]  = '{inst:32'h00812203, rs1v:32'h1000, rs2v:32'h77, hd2:1, d2:3'd1, freeid:3'd5,
                 e_rob:1, e_lsb:1, e_ren:1, e_reg:5'd4, e_imm:32'd8, e_r1:32'h1000, default:0};
    vecs[5]  = '{inst:32'h0020A623, rs1v:32'h2000, rs2v:32'h99, hd2:1, d2:3'd4, cdbv:1, cdbid:3'd4, cdbval:32'hBEEF, freeid:3'd6,
                 e_rob:1, e_lsb:1, e_imm:32'd12, e_r1:32'h2000, e_r2:32'hBEEF, default:0};
    vecs[6]  = '{inst:32'hFE208CE3, rs1v:32'h1, rs2v:32'h2, freeid:3'd7,
                 e_rob:1, e_rs:1, e_imm:32'hFFFFFFF8, e_r1:32'h1, e_r2:32'h2, default:0};
    vecs[7]  = '{inst:32'hABCDE2B7, pc:32'h100, rsf:1, lsbf:1, freeid:3'd0,
                 e_rob:1, e_ren:1, e_reg:5'd5, e_ready:1, e_val:32'hABCDE000, e_imm:32'hABCDE000, default:0};
    vecs[8]  = '{inst:32'hABCDE297, pc:32'h100, freeid:3'd1,
                 e_rob:1, e_ren:1, e_reg:5'd5, e_ready:1, e_val:32'hABCDE100, e_imm:32'hABCDE000, default:0};
    vecs[9]  = '{inst:32'h010000EF, pc:32'h200, freeid:3'd2,
                 e_rob:1, e_ren:1, e_reg:5'd1, e_ready:1, e_val:32'h204, e_imm:32'd16, default:0};
    vecs[10] = '{inst:32'h00500093, robf:1, drain:1, default:0};
    vecs[11] = '{inst:32'h00812203, lsbf:1, drain:1, default:0};
    vecs[12] = '{inst:32'h00500093, rsf:1, drain:1, default:0};
    vecs[13] = '{inst:32'h0000007F, drain:0, default:0};
    vecs[14] = '{inst:32'h00700113, freeid:3'd3,
                 e_rob:1, e_rs:1, e_ren:1, e_reg:5'd2, e_imm:32'd7, default:0};

    // Reset state
    #3;
    chk("reset_if_ready", 32'(bus.if_ready), 32'd0);
    chk("reset_rob_valid", 32'(bus.rob_valid), 32'd0);
    chk("reset_rs_valid", 32'(bus.rs_valid), 32'd0);
    chk("reset_lsb_valid", 32'(bus.lsb_valid), 32'd0);
    chk("reset_rename", 32'(bus.rf_rename_valid), 32'd0);
    #9;
    rst_n = 1'b1;
    cyc();
    chk("post_reset_if_ready", 32'(bus.if_ready), 32'd1);
    chk("post_reset_empty", 32'(bus.rob_valid), 32'd0);

    // Table-driven single-instruction vectors
    for (int i = 0; i < NV; i++) begin
      quiet_inputs();
      push_inst(vecs[i].inst, vecs[i].pc);
      bus.rs1_val_in  = vecs[i].rs1v;
      bus.rs2_val_in  = vecs[i].rs2v;
      bus.has_dep1    = vecs[i].hd1;
      bus.dep1        = vecs[i].d1;
      bus.has_dep2    = vecs[i].hd2;
      bus.dep2        = vecs[i].d2;
      bus.cdb_valid   = vecs[i].cdbv;
      bus.cdb_rob_id  = vecs[i].cdbid;
      bus.cdb_value   = vecs[i].cdbval;
      bus.rob_full    = vecs[i].robf;
      bus.rs_full     = vecs[i].rsf;
      bus.lsb_full    = vecs[i].lsbf;
      bus.rob_free_id = vecs[i].freeid;
      #2;
      chk($sformatf("v%0d_rob_valid", i), 32'(bus.rob_valid), 32'(vecs[i].e_rob));
      chk($sformatf("v%0d_rs_valid", i), 32'(bus.rs_valid), 32'(vecs[i].e_rs));
      chk($sformatf("v%0d_lsb_valid", i), 32'(bus.lsb_valid), 32'(vecs[i].e_lsb));
      chk($sformatf("v%0d_rename_valid", i), 32'(bus.rf_rename_valid), 32'(vecs[i].e_ren));
      if (vecs[i].e_rob) begin
        chk($sformatf("v%0d_issue_rob_id", i), 32'(bus.issue_rob_id), 32'(vecs[i].freeid));
        chk($sformatf("v%0d_rob_inst_addr", i), bus.rob_inst_addr, vecs[i].pc);
        chk($sformatf("v%0d_rob_ready", i), 32'(bus.rob_ready), 32'(vecs[i].e_ready));
        if (vecs[i].e_ready) chk($sformatf("v%0d_rob_value", i), bus.rob_value, vecs[i].e_val);
        if (vecs[i].e_ren) begin
          chk($sformatf("v%0d_rename_reg", i), 32'(bus.rf_rename_reg), 32'(vecs[i].e_reg));
          chk($sformatf("v%0d_rename_tag", i), 32'(bus.rf_rename_rob_id), 32'(vecs[i].freeid));
        end
        chk($sformatf("v%0d_imm", i), bus.imm, vecs[i].e_imm);
        if (vecs[i].e_rs || vecs[i].e_lsb) begin
          chk($sformatf("v%0d_r1", i), bus.r1, vecs[i].e_r1);
          chk($sformatf("v%0d_r2", i), bus.r2, vecs[i].e_r2);
          chk($sformatf("v%0d_has_dep1", i), 32'(bus.has_dep1_out), 32'(vecs[i].e_hd1));
          chk($sformatf("v%0d_has_dep2", i), 32'(bus.has_dep2_out), 32'(vecs[i].e_hd2));
          if (vecs[i].e_hd1) chk($sformatf("v%0d_dep1", i), 32'(bus.dep1_out), 32'(vecs[i].e_d1));
          if (vecs[i].e_hd2) chk($sformatf("v%0d_dep2", i), 32'(bus.dep2_out), 32'(vecs[i].e_d2));
        end
      end
      cyc();
      if (!vecs[i].e_rob) begin
        bus.rob_full = 1'b0;
        bus.rs_full  = 1'b0;
        bus.lsb_full = 1'b0;
        #1;
        chk($sformatf("v%0d_drain", i), 32'(bus.rob_valid), 32'(vecs[i].drain));
        cyc();
      end
    end

    // Fill to depth while the RS is full, then drain one per cycle
    quiet_inputs();
    bus.rs_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.if_valid = 1'b1;
      bus.if_inst  = addi(k + 1, k + 1);
      #1;
      chk($sformatf("fill%0d_if_ready", k), 32'(bus.if_ready), 32'd1);
      chk($sformatf("fill%0d_rs_valid", k), 32'(bus.rs_valid), 32'd0);
      cyc();
    end
    bus.if_valid = 1'b0;
    #1;
    chk("full_if_ready", 32'(bus.if_ready), 32'd0);
    chk("full_rob_valid", 32'(bus.rob_valid), 32'd0);
    bus.rs_full = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.rob_free_id = 3'(k);
      #1;
      chk($sformatf("drain%0d_rs_valid", k), 32'(bus.rs_valid), 32'd1);
      chk($sformatf("drain%0d_issue_rob_id", k), 32'(bus.issue_rob_id), 32'(k));
      chk($sformatf("drain%0d_imm", k), bus.imm, 32'(k + 1));
      cyc();
    end
    #1;
    chk("drained_empty", 32'(bus.rob_valid), 32'd0);
    chk("drained_if_ready", 32'(bus.if_ready), 32'd1);

    // Push and pop in the same cycle keep the occupancy unchanged
    push_inst(addi(1, 9), 32'h0);
    bus.if_valid = 1'b1;
    bus.if_inst  = addi(2, 10);
    #1;
    chk("pushpop_first_imm", bus.imm, 32'd9);
    cyc();
    bus.if_valid = 1'b0;
    #1;
    chk("pushpop_second_valid", 32'(bus.rs_valid), 32'd1);
    chk("pushpop_second_imm", bus.imm, 32'd10);
    cyc();
    #1;
    chk("pushpop_empty", 32'(bus.rob_valid), 32'd0);

    // Flush with three queued entries and a concurrent fetch offer
    bus.rs_full = 1'b1;
    for (int k = 0; k < 3; k++) push_inst(addi(k + 1, 20 + k), 32'h0);
    flush        = 1'b1;
    bus.rs_full  = 1'b0;
    bus.if_valid = 1'b1;
    bus.if_inst  = addi(7, 30);
    #1;
    chk("flush_no_rob_valid", 32'(bus.rob_valid), 32'd0);
    chk("flush_no_rs_valid", 32'(bus.rs_valid), 32'd0);
    cyc();
    flush        = 1'b0;
    bus.if_valid = 1'b0;
    #1;
    chk("flush_empty", 32'(bus.rob_valid), 32'd0);
    chk("flush_if_ready", 32'(bus.if_ready), 32'd1);
    push_inst(addi(3, 42), 32'h0);
    #1;
    chk("post_flush_issue", 32'(bus.rs_valid), 32'd1);
    chk("post_flush_imm", bus.imm, 32'd42);
    cyc();

    // Global ready low freezes pushes and issues
    rdy          = 1'b0;
    bus.if_valid = 1'b1;
    bus.if_inst  = addi(1, 51);
    cyc();
    bus.if_valid = 1'b0;
    rdy          = 1'b1;
    #1;
    chk("frozen_no_push", 32'(bus.rob_valid), 32'd0);
    push_inst(addi(1, 68), 32'h0);
    rdy = 1'b0;
    #1;
    chk("frozen_no_issue", 32'(bus.rs_valid), 32'd0);
    cyc();
    rdy = 1'b1;
    #1;
    chk("unfrozen_issue", 32'(bus.rs_valid), 32'd1);
    chk("unfrozen_imm", bus.imm, 32'd68);
    cyc();

    // Asynchronous reset in the middle of an issue cycle
    bus.rs_full = 1'b1;
    push_inst(addi(1, 85), 32'h0);
    bus.rs_full = 1'b0;
    #1;
    chk("pre_reset_issue", 32'(bus.rob_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_rob_valid", 32'(bus.rob_valid), 32'd0);
    chk("async_reset_rs_valid", 32'(bus.rs_valid), 32'd0);
    chk("async_reset_rename", 32'(bus.rf_rename_valid), 32'd0);
    chk("async_reset_if_ready", 32'(bus.if_ready), 32'd0);
    cyc();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("after_reset_empty", 32'(bus.rob_valid), 32'd0);
    chk("after_reset_if_ready", 32'(bus.if_ready), 32'd1);
    push_inst(32'h0020A623, 32'h300);
    #1;
    chk("store_lsb_valid", 32'(bus.lsb_valid), 32'd1);
    chk("store_no_rename", 32'(bus.rf_rename_valid), 32'd0);
    cyc();
    push_inst(32'hFE208CE3, 32'h304);
    #1;
    chk("branch_rs_valid", 32'(bus.rs_valid), 32'd1);
    chk("branch_no_rename", 32'(bus.rf_rename_valid), 32'd0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
